// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with a registered RGB/sync output stage
// Optional macro VGA_TIMING_TEST_PATTERN_EN swaps PIX_* for an internal 8-bar colour pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CLK_DIV  = 1,
  parameter int COLOR_W  = 4,
  parameter int CW       = 11
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic [COLOR_W-1:0] PIX_R,
  input  logic [COLOR_W-1:0] PIX_G,
  input  logic [COLOR_W-1:0] PIX_B,
  output logic [CW-1:0]      PIX_X,
  output logic [CW-1:0]      PIX_Y,
  output logic               PIX_REQ,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               FRAME_START,
  output logic               LINE_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [31:0] H_ACT_W = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_W = 32'(V_ACTIVE);
  localparam logic [31:0] H_LAST  = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST  = 32'(V_TOTAL - 1);
  localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        HS_IDLE = (HS_POL == 0);
  localparam logic        VS_IDLE = (VS_POL == 0);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end
  if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [3:0]         div_cnt;
  logic [CW-1:0]      h_cnt;
  logic [CW-1:0]      v_cnt;
  logic [31:0]        h_w;
  logic [31:0]        v_w;
  logic               tick;
  logic               h_wrap;
  logic               v_wrap;
  logic               in_active;
  logic               in_hs;
  logic               in_vs;
  logic [COLOR_W-1:0] src_r;
  logic [COLOR_W-1:0] src_g;
  logic [COLOR_W-1:0] src_b;

  // Window compares are done 32 bits wide so an end bound equal to 2^CW still works.
  assign h_w       = 32'(h_cnt);
  assign v_w       = 32'(v_cnt);
  assign tick      = (div_cnt == DIV_LAST);
  assign h_wrap    = (h_w == H_LAST);
  assign v_wrap    = (v_w == V_LAST);
  assign in_active = (h_w < H_ACT_W) && (v_w < V_ACT_W);
  assign in_hs     = (h_w >= HS_BEG) && (h_w < HS_END);
  assign in_vs     = (v_w >= VS_BEG) && (v_w < VS_END);

  assign PIX_X   = h_cnt;
  assign PIX_Y   = v_cnt;
  assign PIX_REQ = RESET_N && ENABLE && tick && in_active;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  logic       unused_pix;

  // Bar k starts at ceil(k*H_ACTIVE/8), which equals floor(h*8/H_ACTIVE) >= k.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_w >= 32'((k * H_ACTIVE + 7) / 8)) bar_idx = 3'(k);
    end
  end

  assign src_r      = {COLOR_W{bar_idx[2]}};
  assign src_g      = {COLOR_W{bar_idx[1]}};
  assign src_b      = {COLOR_W{bar_idx[0]}};
  assign unused_pix = ^{PIX_R, PIX_G, PIX_B};
`else
  assign src_r = PIX_R;
  assign src_g = PIX_G;
  assign src_b = PIX_B;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= 4'd0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!ENABLE) begin
      div_cnt <= 4'd0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
      if (tick) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Strobes are cleared on every non-tick cycle so they last one CLOCK_50 cycle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HS      <= HS_IDLE;
      VGA_VS      <= VS_IDLE;
      VGA_DE      <= 1'b0;
      VGA_RED     <= '0;
      VGA_GREEN   <= '0;
      VGA_BLUE    <= '0;
      FRAME_START <= 1'b0;
      LINE_START  <= 1'b0;
    end else if (!ENABLE) begin
      VGA_HS      <= HS_IDLE;
      VGA_VS      <= VS_IDLE;
      VGA_DE      <= 1'b0;
      VGA_RED     <= '0;
      VGA_GREEN   <= '0;
      VGA_BLUE    <= '0;
      FRAME_START <= 1'b0;
      LINE_START  <= 1'b0;
    end else begin
      FRAME_START <= tick && (h_cnt == '0) && (v_cnt == '0);
      LINE_START  <= tick && (h_cnt == '0);
      if (tick) begin
        VGA_HS    <= in_hs ^ HS_IDLE;
        VGA_VS    <= in_vs ^ VS_IDLE;
        VGA_DE    <= in_active;
        VGA_RED   <= in_active ? src_r : '0;
        VGA_GREEN <= in_active ? src_g : '0;
        VGA_BLUE  <= in_active ? src_b : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen against a raster-position model
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, d;
  } mode_t;

  typedef struct packed {
    logic [21:0] xy;
    logic [5:0]  ctl;
    logic [11:0] rgb;
  } exp_t;

  localparam mode_t MA = '{ha:800, hf:56, hs:120, hb:64, va:600, vf:37, vs:6, vb:23, hp:1, vp:1, d:1};
  localparam mode_t MB = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, hp:0, vp:0, d:2};
  localparam mode_t MC = '{ha:40, hf:4, hs:6, hb:2, va:30, vf:3, vs:2, vb:2, hp:1, vp:1, d:3};
  localparam mode_t MD = '{ha:6, hf:1, hs:0, hb:1, va:4, vf:1, vs:0, vb:1, hp:1, vp:1, d:1};

  logic        clk;
  logic        rst_n [4];
  logic        en    [4];
  logic [3:0]  pr [4], pg [4], pb [4];
  logic [10:0] px [4], py [4];
  logic        rq [4], hsync [4], vsync [4], de [4], fs [4], ls [4];
  logic [3:0]  rr [4], gg [4], bb [4];
  logic [21:0] obs_xy  [4];
  logic [5:0]  obs_ctl [4];
  logic [11:0] obs_rgb [4];

  int ka [4], kb [4], sd [4];
  bit ones [4];
  int kk [4];
  int pass_cnt = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic mode_t mode_of(int i);
    case (i)
      0:       return MA;
      1:       return MB;
      2:       return MC;
      default: return MD;
    endcase
  endfunction

  function automatic logic [3:0] pcol(int i, int x, int y, int off);
    if (ones[i]) return 4'hF;
    return 4'((x * ka[i] + y * kb[i] + sd[i] + off) & 15);
  endfunction

  // Raster model: after k edges since release, k/d pixel ticks have happened; the output
  // stage shows pixel number (ticks-1) of the frame and the counters show pixel number ticks.
  function automatic exp_t model(int i, int k, bit run);
    mode_t m;
    exp_t e;
    int ht, vt, ft, t, ph, pos, q, hq, vq;
    bit act, hon, von;
    logic [2:0] bar;
    m = mode_of(i);
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    ft = ht * vt;
    e = '0;
    e.ctl = {m.hp == 0, m.vp == 0, 4'b0000};
    if (!run) return e;
    t   = k / m.d;
    ph  = k % m.d;
    pos = t % ft;
    e.xy = {11'(pos % ht), 11'(pos / ht)};
    e.ctl[0] = ((pos % ht) < m.ha) && ((pos / ht) < m.va) && (ph == m.d - 1);
    if (t > 0) begin
      q  = (t - 1) % ft;
      hq = q % ht;
      vq = q / ht;
      act = (hq < m.ha) && (vq < m.va);
      hon = (hq >= m.ha + m.hf) && (hq < m.ha + m.hf + m.hs);
      von = (vq >= m.va + m.vf) && (vq < m.va + m.vf + m.vs);
      e.ctl[5] = hon ? (m.hp != 0) : (m.hp == 0);
      e.ctl[4] = von ? (m.vp != 0) : (m.vp == 0);
      e.ctl[3] = act;
      e.ctl[2] = (ph == 0) && (q == 0);
      e.ctl[1] = (ph == 0) && (hq == 0);
      if (act) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
        bar = 3'((hq * 8) / m.ha);
        e.rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
        e.rgb = {pcol(i, hq, vq, 0), pcol(i, hq, vq, 5), pcol(i, hq, vq, 9)};
`endif
      end
    end
    return e;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pr[i] = pcol(i, int'(px[i]), int'(py[i]), 0);
      pg[i] = pcol(i, int'(px[i]), int'(py[i]), 5);
      pb[i] = pcol(i, int'(px[i]), int'(py[i]), 9);
      obs_xy[i]  = {px[i], py[i]};
      obs_ctl[i] = {hsync[i], vsync[i], de[i], fs[i], ls[i], rq[i]};
      obs_rgb[i] = {rr[i], gg[i], bb[i]};
    end
  end

  vga_timing_gen #(.H_ACTIVE(MA.ha), .H_FP(MA.hf), .H_SYNC(MA.hs), .H_BP(MA.hb),
    .V_ACTIVE(MA.va), .V_FP(MA.vf), .V_SYNC(MA.vs), .V_BP(MA.vb), .HS_POL(MA.hp), .VS_POL(MA.vp),
    .CLK_DIV(MA.d), .COLOR_W(4), .CW(11)) u_a (
    .CLOCK_50(clk), .RESET_N(rst_n[0]), .ENABLE(en[0]), .PIX_R(pr[0]), .PIX_G(pg[0]), .PIX_B(pb[0]),
    .PIX_X(px[0]), .PIX_Y(py[0]), .PIX_REQ(rq[0]), .VGA_RED(rr[0]), .VGA_GREEN(gg[0]),
    .VGA_BLUE(bb[0]), .VGA_HS(hsync[0]), .VGA_VS(vsync[0]), .VGA_DE(de[0]),
    .FRAME_START(fs[0]), .LINE_START(ls[0]));

  vga_timing_gen #(.H_ACTIVE(MB.ha), .H_FP(MB.hf), .H_SYNC(MB.hs), .H_BP(MB.hb),
    .V_ACTIVE(MB.va), .V_FP(MB.vf), .V_SYNC(MB.vs), .V_BP(MB.vb), .HS_POL(MB.hp), .VS_POL(MB.vp),
    .CLK_DIV(MB.d), .COLOR_W(4), .CW(11)) u_b (
    .CLOCK_50(clk), .RESET_N(rst_n[1]), .ENABLE(en[1]), .PIX_R(pr[1]), .PIX_G(pg[1]), .PIX_B(pb[1]),
    .PIX_X(px[1]), .PIX_Y(py[1]), .PIX_REQ(rq[1]), .VGA_RED(rr[1]), .VGA_GREEN(gg[1]),
    .VGA_BLUE(bb[1]), .VGA_HS(hsync[1]), .VGA_VS(vsync[1]), .VGA_DE(de[1]),
    .FRAME_START(fs[1]), .LINE_START(ls[1]));

  vga_timing_gen #(.H_ACTIVE(MC.ha), .H_FP(MC.hf), .H_SYNC(MC.hs), .H_BP(MC.hb),
    .V_ACTIVE(MC.va), .V_FP(MC.vf), .V_SYNC(MC.vs), .V_BP(MC.vb), .HS_POL(MC.hp), .VS_POL(MC.vp),
    .CLK_DIV(MC.d), .COLOR_W(4), .CW(11)) u_c (
    .CLOCK_50(clk), .RESET_N(rst_n[2]), .ENABLE(en[2]), .PIX_R(pr[2]), .PIX_G(pg[2]), .PIX_B(pb[2]),
    .PIX_X(px[2]), .PIX_Y(py[2]), .PIX_REQ(rq[2]), .VGA_RED(rr[2]), .VGA_GREEN(gg[2]),
    .VGA_BLUE(bb[2]), .VGA_HS(hsync[2]), .VGA_VS(vsync[2]), .VGA_DE(de[2]),
    .FRAME_START(fs[2]), .LINE_START(ls[2]));

  vga_timing_gen #(.H_ACTIVE(MD.ha), .H_FP(MD.hf), .H_SYNC(MD.hs), .H_BP(MD.hb),
    .V_ACTIVE(MD.va), .V_FP(MD.vf), .V_SYNC(MD.vs), .V_BP(MD.vb), .HS_POL(MD.hp), .VS_POL(MD.vp),
    .CLK_DIV(MD.d), .COLOR_W(4), .CW(11)) u_d (
    .CLOCK_50(clk), .RESET_N(rst_n[3]), .ENABLE(en[3]), .PIX_R(pr[3]), .PIX_G(pg[3]), .PIX_B(pb[3]),
    .PIX_X(px[3]), .PIX_Y(py[3]), .PIX_REQ(rq[3]), .VGA_RED(rr[3]), .VGA_GREEN(gg[3]),
    .VGA_BLUE(bb[3]), .VGA_HS(hsync[3]), .VGA_VS(vsync[3]), .VGA_DE(de[3]),
    .FRAME_START(fs[3]), .LINE_START(ls[3]));

  task automatic start(int i);
    @(negedge clk);
    rst_n[i] = 1'b0;
    en[i] = 1'b1;
    @(negedge clk);
    rst_n[i] = 1'b1;
    kk[i] = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e = model(i, 0, 1'b0);
      total_cnt++;
      if (obs_xy[i] !== e.xy) $display("FAIL reset_xy dut%0d got %h want %h", i, obs_xy[i], e.xy);
      else pass_cnt++;
      total_cnt++;
      if (obs_ctl[i] !== e.ctl) $display("FAIL reset_ctl dut%0d got %b want %b", i, obs_ctl[i], e.ctl);
      else pass_cnt++;
      total_cnt++;
      if (obs_rgb[i] !== e.rgb) $display("FAIL reset_rgb dut%0d got %h want %h", i, obs_rgb[i], e.rgb);
      else pass_cnt++;
    end
  endtask

  task automatic test_hline();
    exp_t e;
    int bad = 0, de_cnt = 0, hs_cnt = 0, ls_cnt = 0, hs_first = 0;
    ka[0] = 1; kb[0] = 0; sd[0] = 0; ones[0] = 1'b0;
    start(0);
    while (kk[0] < 3200 && bad < 8) begin
      @(posedge clk); kk[0]++; @(negedge clk);
      e = model(0, kk[0], 1'b1);
      total_cnt++;
      if (obs_xy[0] !== e.xy) begin bad++; $display("FAIL hline_xy k=%0d got %h want %h", kk[0], obs_xy[0], e.xy); end
      else pass_cnt++;
      total_cnt++;
      if (obs_ctl[0] !== e.ctl) begin bad++; $display("FAIL hline_ctl k=%0d got %b want %b", kk[0], obs_ctl[0], e.ctl); end
      else pass_cnt++;
      total_cnt++;
      if (obs_rgb[0] !== e.rgb) begin bad++; $display("FAIL hline_rgb k=%0d got %h want %h", kk[0], obs_rgb[0], e.rgb); end
      else pass_cnt++;
      if (kk[0] > 1040 && kk[0] <= 2080) begin
        de_cnt += int'(de[0]);
        hs_cnt += int'(hsync[0]);
      end
      if (ls[0]) ls_cnt++;
      if (hsync[0] && hs_first == 0) hs_first = kk[0];
    end
    total_cnt++;
    if (de_cnt !== 800) $display("FAIL hline_de_count got %0d want 800", de_cnt); else pass_cnt++;
    total_cnt++;
    if (hs_cnt !== 120) $display("FAIL hline_hs_count got %0d want 120", hs_cnt); else pass_cnt++;
    total_cnt++;
    if (ls_cnt !== 4) $display("FAIL hline_line_starts got %0d want 4", ls_cnt); else pass_cnt++;
    total_cnt++;
    if (hs_first !== 857) $display("FAIL hline_hs_first_cycle got %0d want 857", hs_first); else pass_cnt++;
    rst_n[0] = 1'b0;
  endtask

  task automatic test_reset_midline();
    exp_t e;
    int bad = 0;
    int run;
    ka[0] = $urandom_range(0, 15); kb[0] = $urandom_range(0, 15); sd[0] = $urandom_range(0, 15);
    ones[0] = 1'b0;
    run = $urandom_range(100, 2000);
    start(0);
    while (kk[0] < run + 1200 && bad < 8) begin
      if (kk[0] == run) begin
        #3 rst_n[0] = 1'b0;
        for (int n = 0; n < 3; n++) begin
          if (n == 0) #1; else @(negedge clk);
          e = model(0, 0, 1'b0);
          total_cnt++;
          if (obs_xy[0] !== e.xy) begin bad++; $display("FAIL rstmid_xy n=%0d got %h want %h", n, obs_xy[0], e.xy); end
          else pass_cnt++;
          total_cnt++;
          if (obs_ctl[0] !== e.ctl) begin bad++; $display("FAIL rstmid_ctl n=%0d got %b want %b", n, obs_ctl[0], e.ctl); end
          else pass_cnt++;
          total_cnt++;
          if (obs_rgb[0] !== e.rgb) begin bad++; $display("FAIL rstmid_rgb n=%0d got %h want %h", n, obs_rgb[0], e.rgb); end
          else pass_cnt++;
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        kk[0] = 0;
        run = -1;
      end
      @(posedge clk); kk[0]++; @(negedge clk);
      e = model(0, kk[0], 1'b1);
      total_cnt++;
      if (obs_xy[0] !== e.xy) begin bad++; $display("FAIL rstrun_xy k=%0d got %h want %h", kk[0], obs_xy[0], e.xy); end
      else pass_cnt++;
      total_cnt++;
      if (obs_ctl[0] !== e.ctl) begin bad++; $display("FAIL rstrun_ctl k=%0d got %b want %b", kk[0], obs_ctl[0], e.ctl); end
      else pass_cnt++;
      total_cnt++;
      if (obs_rgb[0] !== e.rgb) begin bad++; $display("FAIL rstrun_rgb k=%0d got %h want %h", kk[0], obs_rgb[0], e.rgb); end
      else pass_cnt++;
    end
    rst_n[0] = 1'b0;
  endtask

  task automatic test_frame();
    exp_t e;
    int bad = 0, fs_cnt = 0, fs_first = 0;
    ka[2] = $urandom_range(0, 15); kb[2] = $urandom_range(0, 15); sd[2] = $urandom_range(0, 15);
    ones[2] = 1'b0;
    start(2);
    while (kk[2] < 11600 && bad < 8) begin
      @(posedge clk); kk[2]++; @(negedge clk);
      e = model(2, kk[2], 1'b1);
      total_cnt++;
      if (obs_xy[2] !== e.xy) begin bad++; $display("FAIL frame_xy k=%0d got %h want %h", kk[2], obs_xy[2], e.xy); end
      else pass_cnt++;
      total_cnt++;
      if (obs_ctl[2] !== e.ctl) begin bad++; $display("FAIL frame_ctl k=%0d got %b want %b", kk[2], obs_ctl[2], e.ctl); end
      else pass_cnt++;
      total_cnt++;
      if (obs_rgb[2] !== e.rgb) begin bad++; $display("FAIL frame_rgb k=%0d got %h want %h", kk[2], obs_rgb[2], e.rgb); end
      else pass_cnt++;
      if (fs[2]) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = kk[2];
      end
    end
    total_cnt++;
    if (fs_cnt !== 3) $display("FAIL frame_start_count got %0d want 3", fs_cnt); else pass_cnt++;
    total_cnt++;
    if (fs_first !== 3) $display("FAIL frame_start_first got %0d want 3", fs_first); else pass_cnt++;
  endtask

  task automatic test_small();
    exp_t e;
    int bad = 0, hs_low = 0;
    ones[1] = 1'b1;
    start(1);
    while (kk[1] < 288 && bad < 8) begin
      @(posedge clk); kk[1]++; @(negedge clk);
      e = model(1, kk[1], 1'b1);
      total_cnt++;
      if (obs_xy[1] !== e.xy) begin bad++; $display("FAIL small_xy k=%0d got %h want %h", kk[1], obs_xy[1], e.xy); end
      else pass_cnt++;
      total_cnt++;
      if (obs_ctl[1] !== e.ctl) begin bad++; $display("FAIL small_ctl k=%0d got %b want %b", kk[1], obs_ctl[1], e.ctl); end
      else pass_cnt++;
      total_cnt++;
      if (obs_rgb[1] !== e.rgb) begin bad++; $display("FAIL small_rgb k=%0d got %h want %h", kk[1], obs_rgb[1], e.rgb); end
      else pass_cnt++;
      if (kk[1] >= 2 && kk[1] <= 193 && !hsync[1]) hs_low++;
    end
    total_cnt++;
    if (hs_low !== 48) $display("FAIL small_hs_low_cycles got %0d want 48", hs_low); else pass_cnt++;
    rst_n[1] = 1'b0;
  endtask

  task automatic test_no_sync();
    exp_t e;
    int bad = 0, sync_seen = 0;
    ka[3] = $urandom_range(0, 15); kb[3] = $urandom_range(0, 15); sd[3] = $urandom_range(0, 15);
    ones[3] = 1'b0;
    start(3);
    while (kk[3] < 150 && bad < 8) begin
      @(posedge clk); kk[3]++; @(negedge clk);
      e = model(3, kk[3], 1'b1);
      total_cnt++;
      if (obs_ctl[3] !== e.ctl) begin bad++; $display("FAIL nosync_ctl k=%0d got %b want %b", kk[3], obs_ctl[3], e.ctl); end
      else pass_cnt++;
      total_cnt++;
      if (obs_xy[3] !== e.xy) begin bad++; $display("FAIL nosync_xy k=%0d got %h want %h", kk[3], obs_xy[3], e.xy); end
      else pass_cnt++;
      if (hsync[3] || vsync[3]) sync_seen++;
    end
    total_cnt++;
    if (sync_seen !== 0) $display("FAIL nosync_pulses got %0d want 0", sync_seen); else pass_cnt++;
    rst_n[3] = 1'b0;
  endtask

  task automatic test_enable();
    exp_t e;
    int bad = 0;
    int run, len;
    start(2);
    for (int it = 0; it < 4; it++) begin
      ka[2] = $urandom_range(0, 15); kb[2] = $urandom_range(0, 15); sd[2] = $urandom_range(0, 15);
      run = (it == 3) ? 600 : $urandom_range(50, 3000);
      while (kk[2] < run && bad < 8) begin
        @(posedge clk); kk[2]++; @(negedge clk);
        e = model(2, kk[2], 1'b1);
        total_cnt++;
        if (obs_xy[2] !== e.xy) begin bad++; $display("FAIL en_xy k=%0d got %h want %h", kk[2], obs_xy[2], e.xy); end
        else pass_cnt++;
        total_cnt++;
        if (obs_ctl[2] !== e.ctl) begin bad++; $display("FAIL en_ctl k=%0d got %b want %b", kk[2], obs_ctl[2], e.ctl); end
        else pass_cnt++;
        total_cnt++;
        if (obs_rgb[2] !== e.rgb) begin bad++; $display("FAIL en_rgb k=%0d got %h want %h", kk[2], obs_rgb[2], e.rgb); end
        else pass_cnt++;
      end
      if (it < 3) begin
        en[2] = 1'b0;
        len = $urandom_range(1, 5);
        repeat (len) begin
          @(posedge clk); @(negedge clk);
          e = model(2, 0, 1'b0);
          total_cnt++;
          if (obs_xy[2] !== e.xy) begin bad++; $display("FAIL dis_xy it=%0d got %h want %h", it, obs_xy[2], e.xy); end
          else pass_cnt++;
          total_cnt++;
          if (obs_ctl[2] !== e.ctl) begin bad++; $display("FAIL dis_ctl it=%0d got %b want %b", it, obs_ctl[2], e.ctl); end
          else pass_cnt++;
          total_cnt++;
          if (obs_rgb[2] !== e.rgb) begin bad++; $display("FAIL dis_rgb it=%0d got %h want %h", it, obs_rgb[2], e.rgb); end
          else pass_cnt++;
        end
        en[2] = 1'b1;
        kk[2] = 0;
      end
    end
    rst_n[2] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      en[i] = 1'b1;
      ka[i] = 0; kb[i] = 0; sd[i] = 0;
      ones[i] = 1'b0;
      kk[i] = 0;
    end
    test_reset();
    test_hline();
    test_reset_midline();
    test_frame();
    test_small();
    test_no_sync();
    test_enable();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 800x600@72Hz demo timing block.
- Generates HS, VS, display-enable, pixel coordinates and frame/line strobes for any mode via parameters, with programmable sync polarity and a pixel-clock divider.
- Sits between the clock source and the pixel source / DAC pins. Upstream logic supplies RGB for the requested coordinate; this block registers it into alignment with the syncs.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, HS active level (1 = active-high pulse)
VS_POL, 1, VS active level
CLK_DIV, 1, CLOCK_50 cycles per pixel (1..16)
COLOR_W, 4, bits per colour channel
CW, 11, coordinate counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  timing run enable; low forces idle and restarts the frame
PIX_R  in  COLOR_W  red for coordinate presented on PIX_X/PIX_Y this pixel
PIX_G  in  COLOR_W  green, same timing
PIX_B  in  COLOR_W  blue, same timing
PIX_X  out  CW  current horizontal counter (0..H_TOTAL-1)
PIX_Y  out  CW  current vertical counter (0..V_TOTAL-1)
PIX_REQ  out  1  high when the current counter is in the active area and the pixel tick is high
VGA_RED  out  COLOR_W  registered red, blanked outside the active area
VGA_GREEN  out  COLOR_W  registered green
VGA_BLUE  out  COLOR_W  registered blue
VGA_HS  out  1  horizontal sync at HS_POL level during the pulse
VGA_VS  out  1  vertical sync at VS_POL level during the pulse
VGA_DE  out  1  display enable, aligned with RGB
FRAME_START  out  1  one-cycle pulse coincident with output pixel (0,0)
LINE_START  out  1  one-cycle pulse coincident with output pixel x=0 of every line

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 1040 x 666.
- Pixel tick: a divider counter 0..CLK_DIV-1 produces tick = (div==CLK_DIV-1). With CLK_DIV=1, tick is constantly 1. All counters and output registers update only on tick.
- Counters advance on tick. h increments; at H_TOTAL-1, h wraps to 0 and v increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0 on the same tick.
- PIX_X/PIX_Y are the counter registers driven directly (no added delay).
- Active area: h < H_ACTIVE and v < V_ACTIVE.
- Sync windows:
  - HS pulse when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VS pulse when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. VS changes only at the h-wrap, with the v update.
- Output stage is one pipeline register. On tick, it loads HS, VS, DE, LINE_START (h==0) and FRAME_START (h==0 && v==0) computed from the current counters. It also loads RGB = active ? PIX_* : 0.
- Latency: all outputs lag PIX_X/PIX_Y by exactly one pixel tick. Upstream must present PIX_* for the displayed coordinate in the same pixel it is shown on PIX_X/PIX_Y.
- Strobe width:
  - FRAME_START and LINE_START are high for one CLOCK_50 cycle: the cycle after the loading tick, not the whole pixel.
  - VGA_DE, syncs and RGB hold for the whole pixel.
- Reset (RESET_N low, asynchronous): div=0, h=0, v=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_DE=0, RGB=0, FRAME_START=0, LINE_START=0, PIX_REQ=0.
- Reset release: the first tick processes (0,0). FRAME_START is asserted after that tick.
- ENABLE low (synchronous):
  - div, h and v are cleared each cycle.
  - Outputs go to their reset values on the next CLOCK_50 edge, regardless of tick.
  - ENABLE rising restarts at (0,0) exactly as after reset. ENABLE dropping mid-frame abandons the frame, with no partial sync pulse stretching.
- Reset mid-frame: immediate idle levels, with no glitch beyond the asynchronous clear.
- Parameter checks: with H_SYNC=0 or V_SYNC=0 the corresponding sync never asserts. Defaults with CLK_DIV=1 reproduce 800x600@72Hz from 50 MHz.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined: an internal 8-bar colour generator replaces PIX_* in the output mux; the PIX_* inputs are ignored.
  - Bar index = (h * 8) / H_ACTIVE, computed by a compare chain against constant thresholds (no divider).
  - Bar colour bits: red = index[2], green = index[1], blue = index[0]. Each bit is replicated across COLOR_W. Bar 0 is black, bar 7 is white.
  - Timing and latency are unchanged.
- Undefined: RGB comes from PIX_* as above.

Test Plan:
- Defaults, CLK_DIV=1, release reset -> FRAME_START high one cycle after the first edge. VGA_HS first at active level at output pixel h=856, lasting 120 cycles. Line period 1040 cycles; frame period 692640 cycles.
- Defaults -> VGA_VS active for exactly 6 lines, starting at line 637, with edges coincident with output pixel h=0. VGA_DE high for 800 of every 1040 cycles on lines 0..599 and low on lines 600..665.
- Small mode (H 4/1/2/1, V 3/1/1/1, HS_POL=0, VS_POL=0, CLK_DIV=2) -> PIX_X sequence 0..7 wrapping, each value held 2 cycles. VGA_HS low at h=5,6 and high otherwise. RGB=0 whenever DE=0, even with PIX_*=all ones.
- Drive PIX_R = PIX_X[3:0] -> VGA_RED at output pixel x equals x[3:0] (one-tick alignment). VGA_RED=0 at x=800..1039.
- ENABLE low at h=300, v=200 for 5 cycles -> outputs idle on the next edge, PIX_X=PIX_Y=0. On re-enable, FRAME_START is asserted one tick later. Repeat with RESET_N pulsed low mid-line -> immediate idle values.
- VGA_TIMING_TEST_PATTERN_EN defined, defaults -> output x=0..99 RGB=0, x=100..199 blue only all-ones, ..., x=700..799 all channels 0xF. PIX_* toggling has no effect.
